dffram_1rw1r_clr: RTL



---
 rtl/dffram_1rw1r_clr_if.sv | 36 +++
 rtl/dffram_1rw1r_clr.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dffram_1rw1r_clr_if.sv
// Bus interface for dffram_1rw1r_clr.
//
// Groups the clear/busy handshake and both RAM ports. Clock and reset are
// plain ports on the RAM itself.
//   CLR   clear request (sampled when the RAM is ready)
//   BUSY  clear sequence running, port accesses ignored
//   EN0/WE0/A0/Di0/Do0  port 0: read/write, byte-masked writes
//   EN1/A1/Do1          port 1: read-only
// Modports: master drives requests, slave is the RAM side.
interface dffram_1rw1r_clr_if #(
  parameter int unsigned WSIZE = 4,
  parameter int unsigned WORDS = 256
);
  localparam int unsigned AWIDTH = $clog2(WORDS);

  logic                 CLR;
  logic                 BUSY;
  logic                 EN0;
  logic [WSIZE-1:0]     WE0;
  logic [AWIDTH-1:0]    A0;
  logic [8*WSIZE-1:0]   Di0;
  logic [8*WSIZE-1:0]   Do0;
  logic                 EN1;
  logic [AWIDTH-1:0]    A1;
  logic [8*WSIZE-1:0]   Do1;

  modport master (
    output CLR, EN0, WE0, A0, Di0, EN1, A1,
    input  BUSY, Do0, Do1
  );

  modport slave (
    input  CLR, EN0, WE0, A0, Di0, EN1, A1,
    output BUSY, Do0, Do1
  );
endinterface

// File: rtl/dffram_1rw1r_clr.sv
// dffram_1rw1r_clr: flop-based RAM, WORDS x (8*WSIZE) bits.
//
// Port 0 reads or byte-mask writes, port 1 reads; both outputs are
// registered (1-cycle latency) and hold when their enable is low.
// A built-in sequencer zeroes every word after reset and on CLR, so the
// storage array carries no reset. Out-of-range addresses (only possible
// when WORDS is not a power of two) drop writes and read back zero.
//
// Ports:
//   CLK  clock, rising edge
//   RST  asynchronous active-high reset
//   bus  dffram_1rw1r_clr_if.slave (CLR, BUSY, port 0, port 1)
//
// Build option: define DFFRAM_BYPASS_EN to forward a same-cycle port-0
// write into a port-1 read of the same address (merged word). Without it
// port 1 returns the pre-write contents.
module dffram_1rw1r_clr #(
  parameter int unsigned WSIZE = 4,
  parameter int unsigned WORDS = 256
) (
  input logic               CLK,
  input logic               RST,
  dffram_1rw1r_clr_if.slave bus
);
  localparam int unsigned AWIDTH = $clog2(WORDS);
  localparam int unsigned DW     = 8 * WSIZE;
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(WORDS - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state, state_next;
  logic [AWIDTH-1:0] cnt, cnt_next;
  logic              busy;
  logic              clr_we;
  logic              a0_ok, a1_ok;
  logic              wr0, rd0, rd1;
  logic [DW-1:0]     mem [WORDS];
  logic [DW-1:0]     word1;
  logic [DW-1:0]     do0, do1;

  // ---------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy       = 1'b0;
    clr_we     = 1'b0;
    unique case (state)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        // The edge that zeroes the last word is also the one leaving CLEAR,
        // so BUSY lasts exactly WORDS cycles.
        if (cnt == LAST) begin
          state_next = READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      READY: begin
        if (bus.CLR) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
    endcase
  end

  assign bus.BUSY = busy;

  // ---------------------------------------------------------------------
  // Address range checks (compile away for power-of-two depths)
  // ---------------------------------------------------------------------
  if (WORDS == (1 << AWIDTH)) begin : g_pow2
    assign a0_ok = 1'b1;
    assign a1_ok = 1'b1;
  end else begin : g_npow2
    assign a0_ok = (32'(bus.A0) < WORDS);
    assign a1_ok = (32'(bus.A1) < WORDS);
  end

  assign wr0 = ~busy & bus.EN0 & (|bus.WE0) & a0_ok;
  assign rd0 = ~busy & bus.EN0 & ~(|bus.WE0);
  assign rd1 = ~busy & bus.EN1;

  // ---------------------------------------------------------------------
  // Storage: clear writes take priority; no user writes while busy
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[cnt] <= '0;
    end else if (wr0) begin
      for (int unsigned i = 0; i < WSIZE; i++) begin
        if (bus.WE0[i]) begin
          mem[bus.A0][8*i +: 8] <= bus.Di0[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Port 1 read word
  // ---------------------------------------------------------------------
`ifdef DFFRAM_BYPASS_EN
  // Merge the in-flight port-0 bytes over the stored word on a collision.
  always_comb begin
    word1 = mem[bus.A1];
    if (wr0 && (bus.A0 == bus.A1)) begin
      for (int unsigned i = 0; i < WSIZE; i++) begin
        if (bus.WE0[i]) begin
          word1[8*i +: 8] = bus.Di0[8*i +: 8];
        end
      end
    end
  end
`else
  assign word1 = mem[bus.A1];
`endif

  // ---------------------------------------------------------------------
  // Registered read data
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      do0 <= '0;
      do1 <= '0;
    end else begin
      if (rd0) begin
        do0 <= a0_ok ? mem[bus.A0] : '0;
      end
      if (rd1) begin
        do1 <= a1_ok ? word1 : '0;
      end
    end
  end

  assign bus.Do0 = do0;
  assign bus.Do1 = do1;

endmodule
